// File: rtl/accum_nbit_pkg.sv
// accum_nbit_pkg
// Shared definitions for the multi-operand accumulator:
//   - state_t   : controller state encoding (IDLE / ACCUM / DONE, 2 bits)
//   - ACC_ZERO  : accumulator clear value (sliced to WIDTH by the user)
//   - sat_ones  : all-ones saturation value for a given width
// Widths up to ACC_MAX_W bits are supported by the constants below.
package accum_nbit_pkg;

    localparam int ACC_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_MAX_W-1:0] ACC_ZERO = '0;

    // All-ones pattern in the low w bits; used as the saturation ceiling.
    function automatic logic [ACC_MAX_W-1:0] sat_ones(input int unsigned w);
        if (w >= ACC_MAX_W)
            return '1;
        else
            return (ACC_MAX_W'(1) << w) - ACC_MAX_W'(1);
    endfunction

endpackage

// File: rtl/accum_nbit_if.sv
// accum_nbit_if
// Control and stream signals of the accumulator, grouped as one bundle.
//   start/count/busy            : run control
//   in_valid/in_ready/in_data   : operand stream (into the accumulator)
//   out_valid/out_ready/out_sum/out_ovf : result stream (out of the accumulator)
// Modports:
//   master : the side that launches runs, supplies operands, consumes results
//   slave  : the accumulator itself
interface accum_nbit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output start, count, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  start, count, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/adder_nbit.sv
// adder_nbit
// Combinational WIDTH-bit ripple-carry adder, carry-in tied to 0.
// No carry-out is exposed; callers detect wrap themselves.
// Ports:
//   A, B : addends (unsigned)
//   Sum  : A + B modulo 2^WIDTH
module adder_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum
);
    // w_c[i] is the carry into bit i.
    logic [WIDTH-1:0] w_c;

    assign w_c[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign Sum[gi] = A[gi] ^ B[gi] ^ w_c[gi];
            // The carry out of the top bit is deliberately dropped.
            if (gi < WIDTH - 1) begin : g_carry
                assign w_c[gi+1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
            end
        end
    endgenerate
endmodule

// File: rtl/accum_nbit.sv
// accum_nbit
// Sequential multi-operand accumulator around the ripple adder adder_nbit.
// After a start pulse carrying a count, it accepts that many operands over
// a valid/ready stream, sums them, and presents the total with a sticky
// overflow flag on a valid/ready result port.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : accum_nbit_if.slave (start/count/busy, operand stream,
//           result stream)
// Build option:
//   ACCUM_NBIT_SAT_EN : when defined, an overflowing beat saturates the
//                       accumulator to all-ones instead of wrapping.
module accum_nbit
    import accum_nbit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    accum_nbit_if.slave  bus
);
    localparam logic [WIDTH-1:0] C_ZERO = ACC_ZERO[WIDTH-1:0];
`ifdef ACCUM_NBIT_SAT_EN
    localparam logic [ACC_MAX_W-1:0] C_ONES_FULL = sat_ones(WIDTH);
    localparam logic [WIDTH-1:0]     C_SAT       = C_ONES_FULL[WIDTH-1:0];
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_rem;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_carry;
    logic             w_beat;
    logic             w_last;

    adder_nbit #(.WIDTH(WIDTH)) u_adder (
        .A   (r_acc),
        .B   (bus.in_data),
        .Sum (w_sum)
    );

    // The adder has no carry-out: a modular sum smaller than the running
    // total means the addition wrapped.
    assign w_carry = (w_sum < r_acc);

`ifdef ACCUM_NBIT_SAT_EN
    // Once at all-ones, any non-zero operand carries again and zero keeps
    // the value, so saturation holds for the rest of the run by itself.
    assign w_acc_next = w_carry ? C_SAT : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    assign w_beat = (r_state == ST_ACCUM) && bus.in_valid;
    assign w_last = (r_rem == CNT_W'(1));

    // Outputs decode straight from registers; in_ready never looks at
    // in_valid or start.
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_sum   = r_acc;
    assign bus.out_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= C_ZERO;
            r_ovf   <= 1'b0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= C_ZERO;
                        r_ovf   <= 1'b0;
                        r_rem   <= bus.count;
                        r_state <= (bus.count == '0) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    // r_rem is at least 1 here, so the decrement cannot underflow.
                    if (w_beat) begin
                        r_acc <= w_acc_next;
                        r_ovf <= r_ovf | w_carry;
                        r_rem <= r_rem - CNT_W'(1);
                        if (w_last)
                            r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accum_nbit.sv
// tb_accum_nbit
// Directed bench for accum_nbit at WIDTH=8, CNT_W=4. Expected totals come
// from a behavioural model updated as operands are driven and are queued;
// each result popped from the queue is compared when the DUT presents it.
// Honours ACCUM_NBIT_SAT_EN in the model.
module tb_accum_nbit;
    localparam int W = 8;
    localparam int C = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accum_nbit_if #(.WIDTH(W), .CNT_W(C)) bus ();

    accum_nbit #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    int   run_no = 0;
    res_t sb[$];
    int   m_acc;
    logic m_ovf;
    int   m_rem;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int cnt);
        m_acc = 0;
        m_ovf = 1'b0;
        m_rem = cnt;
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        bus.start = 1'b1;
        bus.count = C'(cnt);
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        if (cnt == 0)
            sb.push_back('{sum: W'(0), ovf: 1'b0});
    endtask

    // Drive one operand after 'gaps' stall cycles; optionally pulse start
    // during the stalls, which the DUT must ignore.
    task automatic feed(input int op, input int gaps, input bit poke_start);
        for (int g = 0; g < gaps; g++) begin
            bus.in_valid = 1'b0;
            if (poke_start) begin
                bus.start = 1'b1;
                bus.count = C'(5);
            end
            tick();
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = W'(op);
        check("in_ready_accum", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        m_acc = m_acc + op;
        if (m_acc >= (1 << W)) begin
            m_ovf = 1'b1;
`ifdef ACCUM_NBIT_SAT_EN
            m_acc = (1 << W) - 1;
`else
            m_acc = m_acc - (1 << W);
`endif
        end
        m_rem--;
        if (m_rem == 0)
            sb.push_back('{sum: W'(m_acc), ovf: m_ovf});
    endtask

    // Expect the result on the cycle right after the last beat, then hold
    // out_ready low for 'hold' cycles and check stability.
    task automatic get_result(input int hold);
        int   n;
        res_t exp_r;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("result_latency", 32'(n), 32'd0);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            exp_r = sb.pop_front();
            run_no++;
            $display("run %0d: out_sum=%0d out_ovf=%0d (model sum=%0d ovf=%0d)",
                     run_no, bus.out_sum, bus.out_ovf, exp_r.sum, exp_r.ovf);
            check("out_sum", 32'(bus.out_sum), 32'(exp_r.sum));
            check("out_ovf", 32'(bus.out_ovf), 32'(exp_r.ovf));
            check("done_in_ready", 32'(bus.in_ready), 32'd0);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_sum", 32'(bus.out_sum), 32'(exp_r.sum));
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
        end
    endtask

    // Consume the result; optionally assert start alongside out_ready.
    task automatic consume(input bit with_start);
        bus.out_ready = 1'b1;
        if (with_start) begin
            bus.start = 1'b1;
            bus.count = C'(3);
        end
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("busy_after_consume", 32'(bus.busy), 32'd0);
        check("valid_after_consume", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.count     = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Plain run, in_valid held high: 10+20+30.
        start_run(3);
        feed(10, 0, 1'b0);
        feed(20, 0, 1'b0);
        feed(30, 0, 1'b0);
        get_result(0);
        consume(1'b0);

        // Overflowing run: 200+100.
        start_run(2);
        feed(200, 0, 1'b0);
        feed(100, 0, 1'b0);
        get_result(0);
        consume(1'b0);

        // Back-to-back runs; overflow flag must be clear again.
        start_run(2);
        feed(5, 0, 1'b0);
        feed(6, 0, 1'b0);
        get_result(0);
        consume(1'b0);
        start_run(1);
        feed(9, 0, 1'b0);
        get_result(0);
        consume(1'b0);

        // Zero-length run goes straight to DONE with no operand accepted.
        start_run(0);
        get_result(0);
        consume(1'b0);

        // Stalls, ignored start pulses during ACCUM, held result, and a
        // start coinciding with out_ready in DONE.
        start_run(4);
        feed(1, 2, 1'b1);
        feed(2, 0, 1'b0);
        feed(3, 3, 1'b1);
        feed(4, 1, 1'b0);
        get_result(5);
        consume(1'b1);

        // Reset asserted mid-run after two beats.
        start_run(4);
        feed(5, 0, 1'b0);
        feed(6, 0, 1'b0);
        check("pre_rst_sum", 32'(bus.out_sum), 32'd11);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("mid_rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_run(1);
        feed(7, 0, 1'b0);
        get_result(0);
        consume(1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
